uart_frame_decoder: RTL and testbench

- Sits directly downstream of the UART receiver.
- Consumes its one-cycle byte-done strobe and byte bus, and assembles framed commands: SYNC, CMD, LEN, LEN payload bytes, CHK.
- Checks length and XOR checksum, buffers the payload, and holds each validated frame for the command logic under a valid/ready handshake.
- Reports length, checksum, timeout and overrun errors as one-cycle pulses.

---
 rtl/uart_frame_if.sv | 29 ++
 rtl/uart_frame_decoder.sv | 168 ++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_if.sv
// Handshake and buffer-read bundle between the frame decoder and its neighbours.
// The master side is the receiver plus the command logic, and the slave side is the decoder.
interface uart_frame_if;
  logic       rx_done;
  logic [7:0] rx_byte;
  logic       frame_ready;
  logic [7:0] rd_addr;
  logic       frame_valid;
  logic [7:0] frame_cmd;
  logic [7:0] frame_len;
  logic [7:0] rd_data;
  logic       busy;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;
  logic       overrun;

  modport master (
    output rx_done, rx_byte, frame_ready, rd_addr,
    input  frame_valid, frame_cmd, frame_len, rd_data, busy,
           err_len, err_chk, err_timeout, overrun
  );

  modport slave (
    input  rx_done, rx_byte, frame_ready, rd_addr,
    output frame_valid, frame_cmd, frame_len, rd_data, busy,
           err_len, err_chk, err_timeout, overrun
  );
endinterface

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC/CMD/LEN/payload/CHK frames from received UART bytes.
// Validated frames are held under a valid/ready handshake.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 86800
) (
  input logic         clk,
  input logic         rst,
  uart_frame_if.slave bus
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, len_q, chk_q, idx_q;
  logic [TMR_W-1:0] tmr_q;
  logic [7:0]       payload_mem [MAX_LEN];

  logic in_frame, expire, len_ok, chk_ok, last_payload;
  logic err_len_d, err_chk_d, err_timeout_d, overrun_d;
  logic err_len_q, err_chk_q, err_timeout_q, overrun_q;

  assign in_frame     = (state_q == S_CMD) || (state_q == S_LEN) ||
                        (state_q == S_PAYLOAD) || (state_q == S_CHK);
  // A byte landing in the expiry cycle wins over the timeout.
  assign expire       = in_frame && !bus.rx_done &&
                        (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1));
  assign len_ok       = bus.rx_byte <= 8'(MAX_LEN);
  assign chk_ok       = bus.rx_byte == chk_q;
  assign last_payload = idx_q == (len_q - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    err_len_d     = 1'b0;
    err_chk_d     = 1'b0;
    err_timeout_d = 1'b0;
    overrun_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_done && (bus.rx_byte == SYNC_BYTE)) state_d = S_CMD;
      end
      S_CMD: begin
        if (bus.rx_done) state_d = S_LEN;
      end
      S_LEN: begin
        if (bus.rx_done) begin
          if (!len_ok) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else if (bus.rx_byte == 8'd0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (bus.rx_done && last_payload) state_d = S_CHK;
      end
      S_CHK: begin
        if (bus.rx_done) begin
          if (chk_ok) begin
            state_d = S_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        overrun_d = bus.rx_done;
        if (bus.frame_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (expire) begin
      err_timeout_d = 1'b1;
      state_d       = S_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q         <= '0;
      len_q         <= '0;
      chk_q         <= '0;
      idx_q         <= '0;
      tmr_q         <= '0;
      err_len_q     <= 1'b0;
      err_chk_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      err_len_q     <= err_len_d;
      err_chk_q     <= err_chk_d;
      err_timeout_q <= err_timeout_d;
      overrun_q     <= overrun_d;

      // Any consumed byte (including SYNC entering CMD) restarts the inter-byte timer.
      if (in_frame && !bus.rx_done) tmr_q <= tmr_q + TMR_W'(1);
      else                          tmr_q <= '0;

      if (bus.rx_done) begin
        case (state_q)
          S_CMD: begin
            cmd_q <= bus.rx_byte;
            chk_q <= bus.rx_byte;
          end
          S_LEN: begin
            if (len_ok) begin
              len_q <= bus.rx_byte;
              chk_q <= chk_q ^ bus.rx_byte;
              idx_q <= '0;
            end
          end
          S_PAYLOAD: begin
            chk_q <= chk_q ^ bus.rx_byte;
            idx_q <= idx_q + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the payload buffer is cleared by reset because rd_data must read 00 straight after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) payload_mem[i] <= '0;
    end else if (bus.rx_done && (state_q == S_PAYLOAD)) begin
      payload_mem[idx_q[IDX_W-1:0]] <= bus.rx_byte;
    end
  end

  always_comb begin
    bus.rd_data = 8'h00;
    if (bus.rd_addr < 8'(MAX_LEN)) bus.rd_data = payload_mem[bus.rd_addr[IDX_W-1:0]];
  end

  assign bus.frame_valid = (state_q == S_HOLD);
  assign bus.frame_cmd   = cmd_q;
  assign bus.frame_len   = len_q;
  assign bus.busy        = in_frame;
  assign bus.err_len     = err_len_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder: directed scenarios plus randomized frames
// compared against a field-level frame model.
module tb_uart_frame_decoder;
  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 50;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_frame_if bus();

  uart_frame_decoder #(
    .SYNC_BYTE(SYNC),
    .MAX_LEN(MAX_LEN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int n_len = 0, n_chk = 0, n_to = 0, n_ovr = 0;

  // Pulse counters: a pulse stretched over two cycles counts twice.
  always @(posedge clk) begin
    #1;
    if (bus.err_len)     n_len++;
    if (bus.err_chk)     n_chk++;
    if (bus.err_timeout) n_to++;
    if (bus.overrun)     n_ovr++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_done = 1'b1;
    bus.rx_byte = b;
    @(negedge clk);
    bus.rx_done = 1'b0;
    bus.rx_byte = 8'($urandom);
  endtask

  task automatic send_q(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask

  task automatic release_frame();
    @(negedge clk);
    bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rx_done = 1'b0; bus.rx_byte = 8'h00; bus.frame_ready = 1'b0; bus.rd_addr = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.frame_valid, bus.busy, bus.err_len, bus.err_chk, bus.err_timeout, bus.overrun,
         bus.frame_cmd, bus.frame_len, bus.rd_data} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b b=%b cmd=%h len=%h rd=%h exp all zero",
               bus.frame_valid, bus.busy, bus.frame_cmd, bus.frame_len, bus.rd_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_valid_frame();
    int e0;
    logic [7:0] exp_pl[3];
    exp_pl = '{8'h01, 8'h02, 8'h03};
    e0 = n_len + n_chk + n_to + n_ovr;
    send_q({SYNC, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03});
    checks++;
    if (bus.busy !== 1'b1 || bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL valid_pre_chk got busy=%b valid=%b exp busy=1 valid=0", bus.busy, bus.frame_valid);
    end
    send(8'h13);
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_cmd !== 8'h10 || bus.frame_len !== 8'h03 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL valid_held got v=%b cmd=%h len=%h busy=%b exp v=1 cmd=10 len=03 busy=0",
                         bus.frame_valid, bus.frame_cmd, bus.frame_len, bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      bus.rd_addr = 8'(i);
      #1;
      checks++;
      if (bus.rd_data !== exp_pl[i]) begin
        errors++; $display("FAIL valid_payload[%0d] got %h exp %h", i, bus.rd_data, exp_pl[i]);
      end
    end
    release_frame();
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL valid_release got v=%b busy=%b exp 0 0", bus.frame_valid, bus.busy);
    end
    checks++;
    if (n_len + n_chk + n_to + n_ovr !== e0) begin
      errors++; $display("FAIL valid_no_err got %0d pulses exp 0", n_len + n_chk + n_to + n_ovr - e0);
    end
  endtask

  task automatic test_zero_len_garbage();
    int e0;
    e0 = n_len + n_chk + n_to + n_ovr;
    send_q({8'h00, 8'hFF, SYNC, 8'h22, 8'h00, 8'h22});
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_cmd !== 8'h22 || bus.frame_len !== 8'h00) begin
      errors++; $display("FAIL zero_len got v=%b cmd=%h len=%h exp v=1 cmd=22 len=00",
                         bus.frame_valid, bus.frame_cmd, bus.frame_len);
    end
    checks++;
    if (n_len + n_chk + n_to + n_ovr !== e0) begin
      errors++; $display("FAIL garbage_no_err got %0d pulses exp 0", n_len + n_chk + n_to + n_ovr - e0);
    end
    release_frame();
  endtask

  task automatic test_bad_frames();
    int c0, l0;
    c0 = n_chk; l0 = n_len;
    send_q({SYNC, 8'h10, 8'h01, 8'h05, 8'h00});
    checks++;
    if (n_chk - c0 !== 1 || bus.frame_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL bad_chk got pulses=%0d v=%b busy=%b exp 1 0 0", n_chk - c0, bus.frame_valid, bus.busy);
    end
    send_q({SYNC, 8'h10, 8'h11});
    checks++;
    if (n_len - l0 !== 1 || bus.busy !== 1'b0 || bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL bad_len got pulses=%0d busy=%b v=%b exp 1 0 0", n_len - l0, bus.busy, bus.frame_valid);
    end
    send_q({SYNC, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h13});
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_len !== 8'h03) begin
      errors++; $display("FAIL after_bad_len got v=%b len=%h exp v=1 len=03", bus.frame_valid, bus.frame_len);
    end
    release_frame();
  endtask

  task automatic test_timeout();
    int t0;
    t0 = n_to;
    send_q({SYNC, 8'h10});
    // T silent cycles after the last byte: the pulse shows right after the T-th.
    for (int n = 1; n <= TMO + 1; n++) begin
      @(negedge clk);
      checks++;
      if (bus.err_timeout !== (n == TMO)) begin
        errors++; $display("FAIL timeout_pulse at silent cycle %0d got %b exp %b", n, bus.err_timeout, n == TMO);
      end
    end
    checks++;
    if (n_to - t0 !== 1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL timeout_count got %0d busy=%b exp 1 0", n_to - t0, bus.busy);
    end
    // A byte landing in the expiry cycle (after T-1 silent cycles) is consumed.
    t0 = n_to;
    send_q({SYNC, 8'h10});
    repeat (TMO - 2) @(negedge clk);
    send(8'h00);
    send(8'h10);
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_cmd !== 8'h10 || bus.frame_len !== 8'h00 || n_to !== t0) begin
      errors++; $display("FAIL timeout_boundary got v=%b cmd=%h len=%h to=%0d exp v=1 cmd=10 len=00 to=0",
                         bus.frame_valid, bus.frame_cmd, bus.frame_len, n_to - t0);
    end
    release_frame();
  endtask

  task automatic test_overrun();
    int o0, e0;
    o0 = n_ovr;
    send_q({SYNC, 8'h33, 8'h02, 8'hAA, 8'h55, 8'hCE});
    send(SYNC);
    checks++;
    if (n_ovr - o0 !== 1 || bus.frame_valid !== 1'b1 || bus.frame_cmd !== 8'h33 || bus.frame_len !== 8'h02) begin
      errors++; $display("FAIL overrun_hold got ovr=%0d v=%b cmd=%h len=%h exp 1 1 33 02",
                         n_ovr - o0, bus.frame_valid, bus.frame_cmd, bus.frame_len);
    end
    bus.rd_addr = 8'd1;
    #1;
    checks++;
    if (bus.rd_data !== 8'h55) begin
      errors++; $display("FAIL overrun_payload got %h exp 55", bus.rd_data);
    end
    @(negedge clk);
    bus.rx_done = 1'b1; bus.rx_byte = SYNC; bus.frame_ready = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0; bus.frame_ready = 1'b0;
    checks++;
    if (n_ovr - o0 !== 2 || bus.frame_valid !== 1'b0) begin
      errors++; $display("FAIL overrun_release got ovr=%0d v=%b exp 2 0", n_ovr - o0, bus.frame_valid);
    end
    // Had the dropped SYNC started a frame, these bytes would complete one.
    e0 = n_len + n_chk + n_to;
    send_q({8'h10, 8'h00, 8'h10});
    checks++;
    if (bus.frame_valid !== 1'b0 || bus.busy !== 1'b0 || n_len + n_chk + n_to !== e0) begin
      errors++; $display("FAIL overrun_dropped got v=%b busy=%b exp 0 0", bus.frame_valid, bus.busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0;
    send_q({SYNC, 8'h44, 8'h04, 8'h11, 8'h22});
    bus.rd_addr = 8'd0;
    e0 = n_len + n_chk + n_to + n_ovr;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.frame_valid, bus.busy, bus.err_len, bus.err_chk, bus.err_timeout, bus.overrun,
         bus.frame_cmd, bus.frame_len, bus.rd_data} !== 30'd0) begin
      errors++; $display("FAIL reset_mid got v=%b b=%b cmd=%h len=%h rd=%h exp all zero",
                         bus.frame_valid, bus.busy, bus.frame_cmd, bus.frame_len, bus.rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    send_q({SYNC, 8'h44, 8'h01, 8'h7E, 8'h3B});
    bus.rd_addr = 8'd0;
    #1;
    checks++;
    if (bus.frame_valid !== 1'b1 || bus.frame_cmd !== 8'h44 || bus.frame_len !== 8'h01 || bus.rd_data !== 8'h7E) begin
      errors++; $display("FAIL after_reset got v=%b cmd=%h len=%h rd=%h exp 1 44 01 7E",
                         bus.frame_valid, bus.frame_cmd, bus.frame_len, bus.rd_data);
    end
    checks++;
    if (n_len + n_chk + n_to + n_ovr !== e0) begin
      errors++; $display("FAIL reset_no_err got %0d pulses exp 0", n_len + n_chk + n_to + n_ovr - e0);
    end
    release_frame();
  endtask

  // Reference model: a frame is described by its fields; the outcome follows from the
  // length limit and the XOR checksum computed over those fields.
  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int kind, len, l0, c0, v0;
      logic [7:0] cmd, chk, g, sent_chk;
      logic [7:0] pl[$];
      logic [7:0] stream[$];
      kind = $urandom_range(0, 3);
      cmd  = 8'($urandom);
      len  = (kind == 3) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, MAX_LEN);
      pl   = {};
      for (int i = 0; i < len && kind != 3; i++) pl.push_back(8'($urandom));
      chk = cmd ^ 8'(len);
      foreach (pl[i]) chk = chk ^ pl[i];
      sent_chk = (kind == 2) ? chk ^ 8'($urandom_range(1, 255)) : chk;
      stream = {};
      for (int i = $urandom_range(0, 2); i > 0; i--) begin
        do g = 8'($urandom); while (g == SYNC);
        stream.push_back(g);
      end
      stream.push_back(SYNC);
      stream.push_back(cmd);
      stream.push_back(8'(len));
      if (kind != 3) begin
        foreach (pl[i]) stream.push_back(pl[i]);
        stream.push_back(sent_chk);
      end
      l0 = n_len; c0 = n_chk; v0 = n_to + n_ovr;
      send_q(stream);
      checks++;
      if (n_len - l0 !== int'(kind == 3) || n_chk - c0 !== int'(kind == 2) || n_to + n_ovr !== v0) begin
        errors++; $display("FAIL rand%0d_errs got len=%0d chk=%0d other=%0d exp %0d %0d 0",
                           it, n_len - l0, n_chk - c0, n_to + n_ovr - v0, kind == 3, kind == 2);
      end
      checks++;
      if (bus.frame_valid !== (kind < 2)) begin
        errors++; $display("FAIL rand%0d_valid got %b exp %b", it, bus.frame_valid, kind < 2);
      end
      if (kind < 2) begin
        checks++;
        if (bus.frame_cmd !== cmd || bus.frame_len !== 8'(len)) begin
          errors++; $display("FAIL rand%0d_hdr got cmd=%h len=%h exp %h %h", it, bus.frame_cmd, bus.frame_len, cmd, 8'(len));
        end
        foreach (pl[i]) begin
          bus.rd_addr = 8'(i);
          #1;
          checks++;
          if (bus.rd_data !== pl[i]) begin
            errors++; $display("FAIL rand%0d_pl[%0d] got %h exp %h", it, i, bus.rd_data, pl[i]);
          end
        end
        bus.rd_addr = 8'($urandom_range(MAX_LEN, 255));
        #1;
        checks++;
        if (bus.rd_data !== 8'h00) begin
          errors++; $display("FAIL rand%0d_oob addr %0d got %h exp 00", it, bus.rd_addr, bus.rd_data);
        end
        release_frame();
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_zero_len_garbage();
    test_bad_frames();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
